sum_uart_tx: RTL and testbench

- Serial transmitter stage directly downstream of the sum/latch datapath. Takes the 8-bit result byte presented by the latch/adder logic and drives it onto the UART TX pin as an asynchronous frame.
- Contains a one-entry holding register so the upstream can queue the next byte while the current frame is still shifting out.
- Supports optional parity and 1 or 2 stop bits.

---
 rtl/sum_uart_pkg.sv | 25 ++
 rtl/uart_baud_gen.sv | 43 ++++
 rtl/sum_uart_tx.sv | 176 +++++++++++++++++
 tb/tb_sum_uart_tx.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/sum_uart_pkg.sv
// Shared types and constants for the sum/latch UART transmitter.
package sum_uart_pkg;

    // Frame sequencer states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Parity modes
    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    // Parity bit for a data byte: even mode is the XOR of the bits, odd mode its inverse
    function automatic logic parity_bit(input logic [7:0] data, input int mode);
        logic p;
        p = ^data;
        return (mode == PAR_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-cell timer: counts 0..CLKS_PER_BIT-1 and pulses bit_done on the last count.
// clear restarts the cell so every state entry begins a fresh, full-length cell.
module uart_baud_gen
    import sum_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: restart on clear or at the end of a cell, otherwise advance
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (cnt_q == LAST_CNT) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_done = (cnt_q == LAST_CNT);

endmodule

// File: rtl/sum_uart_tx.sv
// UART transmitter for the sum/latch result byte. One-entry holding register
// in front of the shift register lets the next byte queue during a frame;
// a queued byte follows the previous stop bit with no idle gap.
module sum_uart_tx
    import sum_uart_pkg::*;
#(
    parameter int CLK_FREQ  = 10_000_000,
    parameter int BAUD_RATE = 9600,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_tx_en,
    input  logic [7:0] uart_tx_data,
    output logic       uart_txd,
    output logic       uart_tx_busy,
    output logic       uart_tx_ready,
    output logic       uart_tx_overrun
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam logic LAST_STOP  = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
        $error("sum_uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if (PARITY < PAR_NONE || PARITY > PAR_ODD) begin : g_bad_parity
        $error("sum_uart_tx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
        $error("sum_uart_tx: STOP_BITS must be 1 or 2");
    end

    tx_state_e  state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic [7:0] shift_q, shift_d;
    logic [2:0] idx_q, idx_d;
    logic       stop_q, stop_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;
    logic       ready_q, ready_d;
    logic       ovr_q, ovr_d;

    logic       bit_done_s;
    logic       clear_s;
    logic       accept_s;
    logic       load_s;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (clear_s),
        .bit_done(bit_done_s)
    );

    // Next-state logic for the sequencer, holding register and registered outputs
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        stop_d  = stop_q;

        accept_s = uart_tx_en & ready_q;
        load_s   = hold_full_q & ((state_q == ST_IDLE) |
                   ((state_q == ST_STOP) & bit_done_s & (stop_q == LAST_STOP)));

        case (state_q)
            ST_IDLE: begin
                if (load_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    state_d = ST_DATA;
                    idx_d   = 3'd0;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    if (idx_q == 3'd7) begin
                        state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            ST_PARITY: begin
                if (bit_done_s) begin
                    state_d = ST_STOP;
                    stop_d  = 1'b0;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    if (stop_q == LAST_STOP) begin
                        state_d = load_s ? ST_START : ST_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end else begin
                    stop_d = stop_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Accept and drain never coincide: accepting needs ready, i.e. holding empty
        shift_d     = load_s ? hold_q : shift_q;
        hold_d      = accept_s ? uart_tx_data : hold_q;
        hold_full_d = accept_s ? 1'b1 : (load_s ? 1'b0 : hold_full_q);

        case (state_d)
            ST_IDLE:   txd_d = 1'b1;
            ST_START:  txd_d = 1'b0;
            ST_DATA:   txd_d = shift_d[idx_d];
            ST_PARITY: txd_d = parity_bit(shift_d, PARITY);
            ST_STOP:   txd_d = 1'b1;
            default:   txd_d = 1'b1;
        endcase

        busy_d  = (state_d != ST_IDLE) | hold_full_d;
        ready_d = ~hold_full_d;
        ovr_d   = uart_tx_en & ~ready_q;

        // Fresh bit cell on every state entry; held at zero while idle
        clear_s = (state_q == ST_IDLE) | (state_d != state_q);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
            shift_q     <= 8'h00;
            idx_q       <= 3'd0;
            stop_q      <= 1'b0;
            txd_q       <= 1'b1;
            busy_q      <= 1'b0;
            ready_q     <= 1'b1;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            stop_q      <= stop_d;
            txd_q       <= txd_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            ovr_q       <= ovr_d;
        end
    end

    assign uart_txd        = txd_q;
    assign uart_tx_busy    = busy_q;
    assign uart_tx_ready   = ready_q;
    assign uart_tx_overrun = ovr_q;

endmodule

// File: tb/tb_sum_uart_tx.sv
// Bench for sum_uart_tx: three instances (no parity/1 stop, even/2 stop,
// odd/2 stop) share one stimulus stream and are compared every cycle with a
// frame-level model (frame bit vector + cycle position + pending byte).
module tb_sum_uart_tx;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       en;
    logic [7:0] data;
    logic [2:0] txd_s;
    logic [2:0] busy_s;
    logic [2:0] rdy_s;
    logic [2:0] ovr_s;

    int n_checks;
    int n_fail;

    // Reference model state per instance
    int         cfg_par [3];
    int         cfg_stop[3];
    logic [11:0] fb     [3];
    int         pos     [3];
    bit         act     [3];
    bit         pend    [3];
    logic [7:0] pbyte   [3];
    bit         exp_txd [3];
    bit         exp_busy[3];
    bit         exp_rdy [3];
    bit         exp_ovr [3];

    sum_uart_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .uart_tx_en(en), .uart_tx_data(data),
        .uart_txd(txd_s[0]), .uart_tx_busy(busy_s[0]),
        .uart_tx_ready(rdy_s[0]), .uart_tx_overrun(ovr_s[0]));

    sum_uart_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY(1), .STOP_BITS(2)) dut1 (
        .clk(clk), .reset(reset), .uart_tx_en(en), .uart_tx_data(data),
        .uart_txd(txd_s[1]), .uart_tx_busy(busy_s[1]),
        .uart_tx_ready(rdy_s[1]), .uart_tx_overrun(ovr_s[1]));

    sum_uart_tx #(.CLK_FREQ(160), .BAUD_RATE(10), .PARITY(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .uart_tx_en(en), .uart_tx_data(data),
        .uart_txd(txd_s[2]), .uart_tx_busy(busy_s[2]),
        .uart_tx_ready(rdy_s[2]), .uart_tx_overrun(ovr_s[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line bits of one frame: start, 8 data LSB first, optional parity, stop bits as 1s
    function automatic logic [11:0] frame_bits(input logic [7:0] b, input int par);
        logic [11:0] f;
        f      = 12'hFFF;
        f[0]   = 1'b0;
        f[8:1] = b;
        if (par == 1)      f[9] = ^b;
        else if (par == 2) f[9] = ~(^b);
        return f;
    endfunction

    function automatic int frame_len(input int d);
        return (1 + 8 + ((cfg_par[d] != 0) ? 1 : 0) + cfg_stop[d]) * CPB;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            act[d] = 0; pend[d] = 0; pos[d] = 0;
            exp_txd[d] = 1; exp_busy[d] = 0; exp_rdy[d] = 1; exp_ovr[d] = 0;
        end
    endtask

    // One clock edge of the model; values describe the cycle after the edge
    task automatic model_step(input logic e, input logic [7:0] b);
        bit rdy_before;
        for (int d = 0; d < 3; d++) begin
            rdy_before = exp_rdy[d];
            if (act[d]) begin
                pos[d]++;
                if (pos[d] >= frame_len(d)) act[d] = 0;
            end
            if (!act[d] && pend[d]) begin
                act[d]  = 1;
                pos[d]  = 0;
                fb[d]   = frame_bits(pbyte[d], cfg_par[d]);
                pend[d] = 0;
            end
            if (e && rdy_before) begin
                pend[d]  = 1;
                pbyte[d] = b;
            end
            exp_ovr[d]  = e && !rdy_before;
            exp_txd[d]  = act[d] ? fb[d][pos[d] / CPB] : 1'b1;
            exp_busy[d] = act[d] || pend[d];
            exp_rdy[d]  = !pend[d];
        end
    endtask

    // Per-cycle model update and comparison, sampled 1 time unit after the edge
    always @(posedge clk) begin
        if (reset) model_reset();
        else       model_step(en, data);
        #1;
        for (int d = 0; d < 3; d++) begin
            check_val($sformatf("txd[%0d]", d),     32'(txd_s[d]),  32'(exp_txd[d]));
            check_val($sformatf("busy[%0d]", d),    32'(busy_s[d]), 32'(exp_busy[d]));
            check_val($sformatf("ready[%0d]", d),   32'(rdy_s[d]),  32'(exp_rdy[d]));
            check_val($sformatf("overrun[%0d]", d), 32'(ovr_s[d]),  32'(exp_ovr[d]));
        end
    end

    // Offer one byte for a single cycle; call at a falling edge
    task automatic send(input logic [7:0] b);
        en   = 1'b1;
        data = b;
        @(negedge clk);
        en   = 1'b0;
        data = 8'($urandom);
    endtask

    task automatic wait_ready0();
        int n;
        n = 0;
        while (!rdy_s[0] && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_ready", 32'(rdy_s[0]), 32'd1);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((|busy_s) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val("wait_idle", 32'(|busy_s), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cfg_par[0] = 0; cfg_stop[0] = 1;
        cfg_par[1] = 1; cfg_stop[1] = 2;
        cfg_par[2] = 2; cfg_stop[2] = 2;
        model_reset();
        reset = 1'b1;
        en    = 1'b0;
        data  = 8'h00;

        // Reset with random inputs
        repeat (3) begin
            @(negedge clk);
            en   = 1'($urandom);
            data = 8'($urandom);
        end
        @(negedge clk);
        reset = 1'b0;
        en    = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte
        send(8'h35);
        wait_idle();

        // Back-to-back, then overrun while the second byte is queued
        send(8'hA5);
        wait_ready0();
        send(8'h3C);
        repeat (5) @(negedge clk);
        send(8'hFF);
        wait_idle();

        // Parity byte
        send(8'h07);
        wait_idle();

        // Reset during data bit 3 of 0x5A
        send(8'h5A);
        repeat (70) @(negedge clk);
        reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            check_val($sformatf("async_txd[%0d]", d),  32'(txd_s[d]),  32'd1);
            check_val($sformatf("async_busy[%0d]", d), 32'(busy_s[d]), 32'd0);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(8'hC3);
        wait_idle();

        // Random writes
        repeat (600) begin
            @(negedge clk);
            en   = ($urandom_range(0, 15) == 0);
            data = 8'($urandom);
        end
        @(negedge clk);
        en = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
